// File: rtl/single_port_sram_master.sv
// Initiator-side controller for a single-port SRAM.
// Converts a valid/ready request stream into chip_select / write_enable /
// output_enable bus cycles and returns exactly one response per accepted
// request. The controller owns mem_data only while writing; during reads
// the SRAM drives it. The bus therefore never has two drivers at once.
module single_port_sram_master #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [WIDTH-1:0]      mem_data,
  output logic                  mem_chip_select,
  output logic                  mem_write_enable,
  output logic                  mem_output_enable
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    READ_OE = 3'd3,
    RSP     = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] wdata_q;
  logic             drive_en;
  logic             accept;
  logic             addr_err;

  // A request is taken only in IDLE, which is the only state raising req_ready.
  assign accept   = req_valid && req_ready;
  // DEPTH need not be a power of two, so addresses above it are reachable.
  assign addr_err = 32'(req_addr) >= 32'(DEPTH);

  // The controller releases the bus except while presenting write data.
  assign mem_data = drive_en ? wdata_q : {WIDTH{1'bz}};

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches
    // on paths that do not change state.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_err)       state_nxt = RSP;
          else if (req_write) state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      WRITE:   state_nxt = RSP;
      READ:    state_nxt = READ_OE;
      READ_OE: state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and SRAM controls, decoded from the registered state only.
  always_comb begin
    req_ready         = 1'b0;
    rsp_valid         = 1'b0;
    mem_chip_select   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_output_enable = 1'b0;
    drive_en          = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      WRITE: begin
        mem_chip_select  = 1'b1;
        mem_write_enable = 1'b1;
        drive_en         = 1'b1;
      end
      READ:    mem_chip_select = 1'b1;
      READ_OE: begin
        mem_chip_select   = 1'b1;
        mem_output_enable = 1'b1;
      end
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch and response payload; the payload is frozen while in RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      wdata_q     <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else if (accept) begin
      wdata_q   <= req_wdata;
      rsp_rdata <= '0;
      rsp_err   <= addr_err;
      // An erroring request never reaches the SRAM, so the bus address holds.
      if (!addr_err) mem_address <= req_addr;
    end else if (state == READ_OE) begin
      rsp_rdata <= mem_data;
    end
  end

endmodule

// File: tb/tb_single_port_sram_master.sv
// Directed bench for single_port_sram_master: a DEPTH=16 instance attached
// to a small behavioural SRAM, plus a DEPTH=10 instance for address errors.
module tb_single_port_sram_master;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int DE = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals.
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_address;
  wire  [W-1:0]  mem_data;
  logic          cs, we, oe;

  // Error-test instance signals.
  logic          req_valid_e = 1'b0;
  logic          req_ready_e;
  logic [AW-1:0] req_addr_e  = '0;
  logic          rsp_valid_e;
  logic          rsp_ready_e = 1'b0;
  logic [W-1:0]  rsp_rdata_e;
  logic          rsp_err_e;
  logic [AW-1:0] mem_address_e;
  wire  [W-1:0]  mem_data_e;
  logic          cs_e, we_e, oe_e;

  int n_checks = 0;
  int n_fail   = 0;

  single_port_sram_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_data(mem_data),
    .mem_chip_select(cs), .mem_write_enable(we), .mem_output_enable(oe)
  );

  single_port_sram_master #(.WIDTH(W), .DEPTH(DE), .ADDR_WIDTH(AW)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_e), .req_ready(req_ready_e), .req_write(1'b0),
    .req_addr(req_addr_e), .req_wdata(32'h5555_AAAA),
    .rsp_valid(rsp_valid_e), .rsp_ready(rsp_ready_e), .rsp_rdata(rsp_rdata_e),
    .rsp_err(rsp_err_e), .mem_address(mem_address_e), .mem_data(mem_data_e),
    .mem_chip_select(cs_e), .mem_write_enable(we_e), .mem_output_enable(oe_e)
  );

  // Behavioural SRAM: write on cs&we, register the word on any read cycle,
  // drive the bus only while output_enable is high.
  logic [W-1:0] sram [D];
  logic [W-1:0] sram_q;
  always @(posedge clk) begin
    if (cs && we) sram[mem_address] <= mem_data;
    else if (cs)  sram_q <= sram[mem_address];
  end
  assign mem_data = (cs && oe && !we) ? sram_q : {W{1'bz}};

  // Bus monitors.
  int bus_bad    = 0;
  int bp_access  = 0;
  int cs_e_count = 0;
  logic watch_bp = 1'b0;
  always @(negedge clk) begin
    if (we && oe) bus_bad++;
    if ((we || oe) && $isunknown(mem_data)) bus_bad++;
    if (watch_bp && cs) bp_access++;
    if (cs_e) cs_e_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on the main instance; lat = edges after accept until
  // rsp_valid is seen (0 means visible right after the accept edge).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                       output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Accept the pending response after the given number of stall cycles.
  task automatic take(input int stall);
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] exp_d;

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_controls", {cs, we, oe}, 3'b000);
    check("rst_mem_address", mem_address, 0);
    check("rst_rsp_payload", {rsp_err, rsp_rdata}, 0);

    // Write then read back.
    issue(1'b1, 4'd3, 32'hDEAD_BEEF, lat);
    check("wr_latency", lat, 1);
    check("wr_rsp", {rsp_err, rsp_rdata}, 0);
    take(0);
    issue(1'b0, 4'd3, 32'h0, lat);
    check("rd_latency", lat, 2);
    check("rd_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'hDEAD_BEEF});
    take(0);

    // Backpressure on a read of address 0.
    issue(1'b1, 4'd0, 32'h0000_1234, lat);
    take(1);
    issue(1'b0, 4'd0, 32'h0, lat);
    check("bp_latency", lat, 2);
    watch_bp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0000_1234);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    watch_bp = 1'b0;
    check("bp_no_access", bp_access, 0);
    take(0);
    @(negedge clk);
    check("bp_back_idle", {req_ready, rsp_valid}, 2'b10);

    // Out-of-range requests on the DEPTH=10 instance (12, then boundary 10).
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid_e = 1'b1;
      req_addr_e  = (i == 0) ? 4'd12 : 4'd10;
      @(posedge clk);
      #1 req_valid_e = 1'b0;
      @(negedge clk);
      check("err_rsp_valid", rsp_valid_e, 1);
      check("err_payload", {rsp_err_e, rsp_rdata_e}, {1'b1, 32'h0});
      rsp_ready_e = 1'b1;
      @(posedge clk);
      #1 rsp_ready_e = 1'b0;
    end
    check("err_no_cs", cs_e_count, 0);

    // Stream: fill every word, then read all back with random backpressure.
    for (int a = 0; a < D; a++) begin
      issue(1'b1, AW'(a), W'(a * 3), lat);
      check("st_wr_latency", lat, 1);
      take($urandom_range(0, 3));
    end
    for (int a = 0; a < D; a++) begin
      issue(1'b0, AW'(a), 32'hFFFF_FFFF, lat);
      exp_d = W'(a * 3);
      check("st_rd_data", {rsp_err, rsp_rdata}, {1'b0, exp_d});
      take($urandom_range(0, 3));
    end
    check("st_bus_clean", bus_bad, 0);

    // Reset asserted while the controller sits in READ_OE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5; req_wdata = 32'h1111_2222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_oe", {cs, we, oe}, 3'b101);
    rst_n = 1'b0;
    #1;
    check("midrst_controls", {cs, we, oe}, 3'b000);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_no_drive", mem_data === 32'h1111_2222, 0);
    check("midrst_mem_address", mem_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
